// File: rtl/uart_char_source.sv
// uart_char_source: 8N1 serial receiver feeding a small byte FIFO, drained
// as a paced cin/we write stream for the character-plane controller.
module uart_char_source #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16,
  parameter int WE_GAP     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [7:0]                    cin,
  output logic                          we,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BCW = $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int GW  = $clog2(WE_GAP + 1);

  localparam logic [BCW-1:0] BC_HALF  = BCW'(DIV / 2 - 1);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(DIV - 1);
  localparam logic [BCW-1:0] BC_ONE   = BCW'(1);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0]  GAP_LOAD = GW'(WE_GAP);
  localparam logic [GW-1:0]  GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  // ---------------- input synchroniser and falling-edge detect ----------
  logic sync1_reg, sync2_reg, prev_reg;
  logic rx_s, fall;

  assign rx_s = sync2_reg;
  assign fall = prev_reg & ~rx_s;

  // Two-flop synchroniser plus one history flop; idle-high on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= rx;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // ---------------- receive FSM ----------------------------------------
  rx_state_t      state_reg, state_next;
  logic [BCW-1:0] bc_reg, bc_next;
  logic [2:0]     bi_reg, bi_next;
  logic [7:0]     shift_reg, shift_next;
  logic           good_stop, bad_stop;

  // State register for the receiver.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      bc_reg    <= '0;
      bi_reg    <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      bc_reg    <= bc_next;
      bi_reg    <= bi_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic: sample start at half a bit, then every full bit.
  always_comb begin
    state_next = state_reg;
    bc_next    = bc_reg + BC_ONE;
    bi_next    = bi_reg;
    shift_next = shift_reg;
    good_stop  = 1'b0;
    bad_stop   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        bc_next = '0;
        if (fall) state_next = START;
      end
      START: begin
        if (bc_reg == BC_HALF) begin
          bc_next    = '0;
          bi_next    = '0;
          // A high sample here means the fall was only a glitch.
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bc_reg == BC_LAST) begin
          bc_next            = '0;
          shift_next[bi_reg] = rx_s;
          if (bi_reg == 3'd7) state_next = STOP;
          else                bi_next    = bi_reg + 3'd1;
        end
      end
      STOP: begin
        if (bc_reg == BC_LAST) begin
          bc_next    = '0;
          state_next = IDLE;
          good_stop  = rx_s;
          bad_stop   = ~rx_s;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- received-byte staging -----------------------------
  logic       push_pend_reg;
  logic [7:0] push_data_reg;
  logic       frame_err_reg;

  // Stage the completed byte one cycle before it enters the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_pend_reg <= 1'b0;
      push_data_reg <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      push_pend_reg <= good_stop;
      push_data_reg <= shift_reg;
      frame_err_reg <= bad_stop;
    end
  end

  // ---------------- FIFO and paced output ------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [GW-1:0] gc_reg;
  logic [7:0]    cin_reg;
  logic          we_reg, overflow_reg;
  logic          pop, push_ok;

  assign pop     = (count_reg != '0) && (gc_reg == '0);
  assign push_ok = push_pend_reg && ((count_reg != DEPTH_C) || pop);

  // Buffer storage; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data_reg;
  end

  // Pointers, occupancy, sticky overflow and the inter-write gap counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      gc_reg       <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push_ok && !pop)      count_reg <= count_reg + CNT_ONE;
      else if (pop && !push_ok) count_reg <= count_reg - CNT_ONE;
      if (push_pend_reg && !push_ok) overflow_reg <= 1'b1;
      if (pop)                gc_reg <= GAP_LOAD;
      else if (gc_reg != '0)  gc_reg <= gc_reg - GAP_ONE;
    end
  end

  // Registered read port: head byte and one-cycle strobe on each pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      cin_reg <= '0;
      we_reg  <= 1'b0;
    end else begin
      we_reg <= pop;
      if (pop) cin_reg <= mem[rd_ptr_reg];
    end
  end

  assign cin        = cin_reg;
  assign we         = we_reg;
  assign overflow   = overflow_reg;
  assign frame_err  = frame_err_reg;
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_uart_char_source.sv
// Scoreboard bench for uart_char_source: DIV=16, FIFO_DEPTH=4.
// dut_a uses WE_GAP=4, dut_b uses WE_GAP=2000 to hold the pop path off.
module tb_uart_char_source;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] cin_a, cin_b;
  logic       we_a, we_b, overflow_a, overflow_b, frame_err_a, frame_err_b;
  logic [2:0] fifo_count_a, fifo_count_b;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  int lat_start = 0;
  bit lat_arm = 1'b0;
  int ferr_cnt = 0;

  uart_char_source #(.CLK_HZ(1600), .BAUD(100), .FIFO_DEPTH(4), .WE_GAP(4)) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .cin(cin_a), .we(we_a),
    .overflow(overflow_a), .frame_err(frame_err_a), .fifo_count(fifo_count_a)
  );

  uart_char_source #(.CLK_HZ(1600), .BAUD(100), .FIFO_DEPTH(4), .WE_GAP(2000)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .cin(cin_b), .we(we_b),
    .overflow(overflow_b), .frame_err(frame_err_b), .fifo_count(fifo_count_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // One bit period = 16 clocks, changed on the falling edge.
  task automatic drive_bit(input bit sel, input logic v);
    @(negedge clk);
    set_rx(sel, v);
    repeat (15) @(negedge clk);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] d, input logic stop, input bit arm);
    @(negedge clk);
    set_rx(sel, 1'b0);
    if (arm) begin
      lat_start = cyc;
      lat_arm   = 1'b1;
    end
    repeat (15) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    drive_bit(sel, stop);
    set_rx(sel, 1'b1);
  endtask

  task automatic wait_drain(input bit sel, input int budget, input string name);
    int n;
    n = 0;
    while (((sel ? exp_b.size() : exp_a.size()) != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(name, sel ? exp_b.size() : exp_a.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    fork
      // Monitor: pop expected bytes whenever either DUT strobes we.
      begin : monitor
        int  last_a, last_b;
        bit  have_a, have_b, ferr_prev;
        logic [7:0] e;
        have_a = 1'b0; have_b = 1'b0; ferr_prev = 1'b0;
        last_a = 0; last_b = 0;
        forever begin
          @(negedge clk);
          if (reset) begin
            have_a = 1'b0;
            have_b = 1'b0;
          end
          if (we_a) begin
            $display("dut_a write cin=0x%02h at cycle %0d", cin_a, cyc);
            if (exp_a.size() == 0) check("unexpected_we_a", {24'd0, cin_a}, 32'hFFFF_FFFF);
            else begin
              e = exp_a.pop_front();
              check("cin_a", {24'd0, cin_a}, {24'd0, e});
            end
            if (have_a) check("gap_a_ge5", (cyc - last_a >= 5) ? 1 : 0, 1);
            if (lat_arm) begin
              // Frame start drive to we: 3 (sync+fall) + 8 (half bit)
              // + 9*16 (data+stop) + 2 (stage, pop) = 157 clocks.
              check("latency_a", cyc - lat_start, 157);
              lat_arm = 1'b0;
            end
            have_a = 1'b1;
            last_a = cyc;
          end
          if (we_b) begin
            $display("dut_b write cin=0x%02h at cycle %0d", cin_b, cyc);
            if (exp_b.size() == 0) check("unexpected_we_b", {24'd0, cin_b}, 32'hFFFF_FFFF);
            else begin
              e = exp_b.pop_front();
              check("cin_b", {24'd0, cin_b}, {24'd0, e});
            end
            if (have_b) check("gap_b_ge2001", (cyc - last_b >= 2001) ? 1 : 0, 1);
            have_b = 1'b1;
            last_b = cyc;
          end
          if (frame_err_a) begin
            ferr_cnt++;
            if (ferr_prev) check("frame_err_a_width", 2, 1);
          end
          ferr_prev = frame_err_a;
          if (frame_err_b) check("frame_err_b", 1, 0);
        end
      end
    join_none

    // Reset state
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check("rst_cin", cin_a, 0);
    check("rst_we", we_a, 0);
    check("rst_overflow", overflow_a, 0);
    check("rst_frame_err", frame_err_a, 0);
    check("rst_fifo_count", fifo_count_a, 0);
    idle(5);

    // 1. Single byte with latency check
    exp_a.push_back(8'h41);
    send_byte(1'b0, 8'h41, 1'b1, 1'b1);
    wait_drain(1'b0, 200, "drain_single");
    check("t1_fifo_count", fifo_count_a, 0);
    check("t1_overflow", overflow_a, 0);
    check("t1_ferr_cnt", ferr_cnt, 0);
    check("t1_cin_hold", cin_a, 8'h41);

    // 2. Back-to-back frames
    exp_a.push_back(8'h48);
    exp_a.push_back(8'h49);
    send_byte(1'b0, 8'h48, 1'b1, 1'b0);
    send_byte(1'b0, 8'h49, 1'b1, 1'b0);
    wait_drain(1'b0, 200, "drain_b2b");
    check("t2_fifo_count", fifo_count_a, 0);
    check("t2_overflow", overflow_a, 0);

    // 3. Glitch: 5-cycle low pulse
    @(negedge clk);
    rx_a = 1'b0;
    idle(5);
    rx_a = 1'b1;
    idle(300);
    check("t3_ferr_cnt", ferr_cnt, 0);
    check("t3_fifo_count", fifo_count_a, 0);
    check("t3_cin_hold", cin_a, 8'h49);

    // 4. Framing error on 0x55
    send_byte(1'b0, 8'h55, 1'b0, 1'b0);
    idle(20);
    check("t4_ferr_cnt", ferr_cnt, 1);
    check("t4_fifo_count", fifo_count_a, 0);
    check("t4_overflow", overflow_a, 0);

    // 5. Overflow on dut_b: 0x30 drains at once, 0x31..0x34 fill, 0x35 drops
    for (int i = 0; i < 5; i++) begin
      exp_b.push_back(8'h30 + 8'(i));
      send_byte(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0);
    end
    check("t5_full_count", fifo_count_b, 4);
    check("t5_no_ovf_yet", overflow_b, 0);
    send_byte(1'b1, 8'h35, 1'b1, 1'b0);
    idle(4);
    check("t5_full_count2", fifo_count_b, 4);
    check("t5_overflow", overflow_b, 1);
    wait_drain(1'b1, 12000, "drain_overflow");
    check("t5_fifo_empty", fifo_count_b, 0);
    check("t5_overflow_sticky", overflow_b, 1);
    check("t5_a_overflow", overflow_a, 0);

    // 6. Reset during data bit 3 of 0x7E, then a clean 0x31
    @(negedge clk);
    rx_a = 1'b0;
    idle(15);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, (8'h7E >> i) & 8'h01);
    @(negedge clk);
    rx_a = 1'b1;
    idle(8);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check("t6_cin", cin_a, 0);
    check("t6_we", we_a, 0);
    check("t6_overflow_b", overflow_b, 0);
    check("t6_frame_err", frame_err_a, 0);
    check("t6_fifo_count", fifo_count_a, 0);
    idle(200);
    check("t6_no_stray", exp_a.size(), 0);
    exp_a.push_back(8'h31);
    send_byte(1'b0, 8'h31, 1'b1, 1'b0);
    wait_drain(1'b0, 200, "drain_after_reset");
    check("t6_cin_final", cin_a, 8'h31);
    check("t6_ferr_cnt", ferr_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_char_source.md
Name: uart_char_source

Overview:
- Upstream character source for the text-mode VGA output path.
- Receives 8N1 serial bytes on `rx`, buffers them in a small FIFO, and presents them as a `cin`/`we` write stream.
- The stream drives the character-plane controller's 8-bit character input and write-enable.
- Writes are paced by a minimum gap so the downstream feeder always completes one character before the next arrives.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate; DIV = CLK_HZ/BAUD, integer truncated, must be >= 8.
- FIFO_DEPTH, 16, byte buffer depth; power of two, >= 2.
- WE_GAP, 4, minimum idle cycles between consecutive `we` pulses; >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- cin  output  8  character code to the character plane; valid when `we`=1.
- we  output  1  one-cycle write strobe for `cin`.
- overflow  output  1  sticky; set when a received byte is dropped because the FIFO is full.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

Behaviour:
- Reset values, applied on the clock edge with `reset`=1:
  - `cin`=0, `we`=0, `overflow`=0, `frame_err`=0, `fifo_count`=0.
  - FIFO pointers 0; RX FSM in IDLE; baud counter 0.
  - Both synchroniser flops = 1; gap counter 0.
- Reset overrides everything, including a byte mid-reception (discarded) and a pending pop.
- Input sync: `rx` passes through a 2-flop synchroniser giving rx_s. An edge detector on rx_s gives `fall` = previous rx_s 1, current rx_s 0.
- RX FSM, with a baud counter `bc` (0..DIV-1) and bit index `bi` (0..7):
  - IDLE: on `fall`, go to START with bc=0.
  - START: when bc = DIV/2 - 1, sample rx_s.
    - If 0: go to DATA with bc=0, bi=0.
    - If 1: treat as a glitch and return to IDLE; no output, no error.
  - DATA: when bc = DIV-1, sample rx_s into shift bit `bi` (LSB first) and set bc=0. After bi=7 go to STOP.
  - STOP: when bc = DIV-1, sample rx_s.
    - If 1: push the byte.
    - If 0: pulse `frame_err` the next cycle and discard the byte.
    - Either way, return to IDLE. A new start requires a fresh `fall`.
- Samples therefore land at bit centres: start at DIV/2, each data bit DIV later.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits; pointers wrap modulo FIFO_DEPTH.
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, `overflow` is set, and `overflow` stays 1 until reset.
  - Simultaneous push and pop: count is unchanged, both pointers advance.
  - `fifo_count` is registered and reflects all pushes and pops of the previous edge.
- Output pacing:
  - The gap counter `gc` loads WE_GAP on every pop and decrements to 0 otherwise.
  - A pop occurs on a cycle where count > 0 and gc = 0.
  - On a pop, the next edge sets `cin` to the FIFO head and `we`=1 for exactly one cycle.
  - `cin` holds its last value between pulses.
  - Consecutive `we` pulses are separated by at least WE_GAP low cycles. With WE_GAP=4, `we` is high at T, low at T+1..T+4, and may be high again at T+5.
- Latency: a byte pushed at edge T (FIFO previously empty, gc=0) gives `we`=1 with that byte at edge T+2. Edge T+1 registers the count; edge T+2 registers the pop. This latency is fixed.
- Empty FIFO: `we` stays 0, no reads.
- `frame_err` and a push never coincide; one stop-bit sample yields exactly one of the two.

Test Plan (CLK_HZ=1600, BAUD=100 → DIV=16, FIFO_DEPTH=4, WE_GAP=4):
1. Single byte: reset 2 cycles, then send 0x41 on `rx` (start, LSB-first data, stop) → exactly one `we` pulse with `cin`=0x41, two cycles after the stop-bit sample. `fifo_count` returns to 0; `frame_err`=0, `overflow`=0.
2. Back-to-back: send 0x48, 0x49 with no idle between frames → two `we` pulses, `cin`=0x48 then 0x49, in order, with gap ≥ 4 cycles.
3. Glitch: drive `rx` low for 5 cycles, then high → no FSM exit from IDLE after START, no `we`, no `frame_err`.
4. Framing error: send 0x55 with the stop bit held 0 → `frame_err` high exactly one cycle, no `we`, `fifo_count` stays 0.
5. Overflow: hold the pop path off by sending 6 bytes 0x30..0x35 at max rate with WE_GAP=2000 override → the first pop drains 0x30. Later bytes fill the FIFO; bytes arriving while `fifo_count`=4 are dropped with `overflow`=1 sticky. Output order is strictly ascending with no duplicates.
6. Reset mid-frame: assert `reset` during DATA bit 3 of 0x7E → no `we` for that byte, all outputs 0. A following clean 0x31 is delivered correctly.
